multi_cycle_control: RTL and testbench

Moore control FSM for the multi-cycle CPU and the direct upstream driver of the shared instruction/data memory. Generates mem_write, i_or_d (PC vs ALUOut address select), ir_write and all datapath/PC enables from the opcode/funct held in the instruction register. Also counts retired instructions and flags undecodable opcodes.

---
 rtl/multi_cycle_control.sv | 166 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle CPU; outputs decode from state same-cycle (pc_en also uses zero).
// No backpressure: advances one state every clk; illegal_op and instr_count are registered.
module multi_cycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2b,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] FUNCT_JR = 6'h0d,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JR        = 4'd11,
        S_ADDI_EXEC = 4'd12,
        S_ADDI_WB   = 4'd13
    } state_t;

    state_t cur, nxt;
    logic   pc_write, pc_write_cond, illegal_dec, retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_IDLE;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            cur        <= nxt;
            illegal_op <= illegal_dec;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        nxt           = S_FETCH;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal_dec   = 1'b0;
        retire        = 1'b0;
        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                nxt       = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = (funct == FUNCT_JR) ? S_JR : S_R_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    default: begin
                        nxt         = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                i_or_d = 1'b1;
                nxt    = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                retire    = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            // Codes 14/15 are unreachable; recover to FETCH with every control low.
            default: nxt = S_FETCH;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = cur;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control; a second 3-bit-counter instance exercises counter wrap.
module tb_multi_cycle_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, zero;
    logic [5:0]  opcode, funct;
    logic        i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [15:0] instr_count;

    logic        s_i_or_d, s_mem_write, s_ir_write, s_reg_dst, s_mem_to_reg, s_reg_write, s_alu_src_a, s_pc_en, s_illegal_op;
    logic [1:0]  s_alu_src_b, s_alu_op, s_pc_source;
    logic [3:0]  s_state;
    logic [2:0]  s_instr_count;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .pc_en(pc_en),
        .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    multi_cycle_control #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .i_or_d(s_i_or_d), .mem_write(s_mem_write), .ir_write(s_ir_write), .reg_dst(s_reg_dst),
        .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write), .alu_src_a(s_alu_src_a),
        .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .pc_source(s_pc_source), .pc_en(s_pc_en),
        .state(s_state), .illegal_op(s_illegal_op), .instr_count(s_instr_count)
    );

    wire [13:0] obs_ctl = {i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                           alu_src_a, alu_src_b, alu_op, pc_source, pc_en};

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] ctl;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_count = '0;
    logic        last_ill = 1'b0;

    function automatic logic [13:0] exp_ctrl(input logic [3:0] s, input logic z);
        logic iod, mw, irw, rd, m2r, rw, sa, pe;
        logic [1:0] sb, ao, ps;
        {iod, mw, irw, rd, m2r, rw, sa, pe} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            4'd1:        begin irw = 1; sb = 2'b01; pe = 1; end
            4'd2:        sb = 2'b11;
            4'd3, 4'd12: begin sa = 1; sb = 2'b10; end
            4'd4:        iod = 1;
            4'd5:        begin rw = 1; m2r = 1; end
            4'd6:        begin iod = 1; mw = 1; end
            4'd7:        begin sa = 1; ao = 2'b10; end
            4'd8:        begin rw = 1; rd = 1; end
            4'd9:        begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            4'd10:       begin ps = 2'b10; pe = 1; end
            4'd11:       begin ps = 2'b11; pe = 1; end
            4'd13:       rw = 1;
            default:     ;
        endcase
        return {iod, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pe};
    endfunction

    // Starts and ends #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string name);
        logic [3:0] seq[$];
        exp_t e;
        int n;
        seq.push_back(4'd1);
        seq.push_back(4'd2);
        case (op)
            6'h00: if (fn == 6'h0d) seq.push_back(4'd11);
                   else begin seq.push_back(4'd7); seq.push_back(4'd8); end
            6'h23: begin seq.push_back(4'd3); seq.push_back(4'd4); seq.push_back(4'd5); end
            6'h2b: begin seq.push_back(4'd3); seq.push_back(4'd6); end
            6'h04: seq.push_back(4'd9);
            6'h02: seq.push_back(4'd10);
            6'h08: begin seq.push_back(4'd12); seq.push_back(4'd13); end
            default: ;
        endcase
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            e.st  = seq[i];
            e.ctl = exp_ctrl(seq[i], z);
            e.ill = (i == 0) ? last_ill : 1'b0;
            e.cnt = exp_count;
            q.push_back(e);
        end
        zero = z;
        while (q.size() > 0) begin
            e = q.pop_front();
            // Opcode/funct only matter in DECODE and MEM_ADDR; scramble them elsewhere.
            if (e.st == 4'd2 || e.st == 4'd3) begin
                opcode = op; funct = fn;
            end else begin
                opcode = 6'($urandom); funct = 6'($urandom);
            end
            @(negedge clk);
            tests++;
            if (state !== e.st) begin
                fails++; $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
            end
            tests++;
            if (obs_ctl !== e.ctl) begin
                fails++; $display("FAIL %s controls in state %0d: got %b expected %b", name, e.st, obs_ctl, e.ctl);
            end
            tests++;
            if (illegal_op !== e.ill) begin
                fails++; $display("FAIL %s illegal_op in state %0d: got %b expected %b", name, e.st, illegal_op, e.ill);
            end
            tests++;
            if (instr_count !== e.cnt || s_instr_count !== e.cnt[2:0]) begin
                fails++; $display("FAIL %s instr_count: got %h/%h expected %h/%h", name, instr_count, s_instr_count, e.cnt, e.cnt[2:0]);
            end
            @(posedge clk); #1;
        end
        last_ill = (n == 2);
        if (n > 2) exp_count++;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (state !== 4'd0 || obs_ctl !== 14'd0) begin
            fails++; $display("FAIL reset_hold: state %0d ctl %b, expected 0 and all zero", state, obs_ctl);
        end
        tests++;
        if (instr_count !== 16'd0 || illegal_op !== 1'b0) begin
            fails++; $display("FAIL reset_regs: count %h illegal %b, expected 0 0", instr_count, illegal_op);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (state !== 4'd1 || pc_en !== 1'b1 || ir_write !== 1'b1) begin
            fails++; $display("FAIL reset_release: state %0d pc_en %b ir_write %b, expected 1 1 1", state, pc_en, ir_write);
        end
        exp_count = '0; last_ill = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h00, 1'b0, "rtype_add");
        run_instr(6'h00, 6'h22, 1'b1, "rtype_sub");
    endtask

    task automatic test_load_store();
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h2b, 6'h00, 1'b0, "sw");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
    endtask

    task automatic test_jump();
        run_instr(6'h02, 6'h00, 1'b0, "j");
        run_instr(6'h00, 6'h0d, 1'b0, "jr");
        run_instr(6'h08, 6'h0d, 1'b1, "addi");
    endtask

    task automatic test_illegal();
        run_instr(6'h3f, 6'h00, 1'b0, "illegal_3f");
        run_instr(6'h11, 6'h0d, 1'b0, "illegal_11");
        run_instr(6'h02, 6'h00, 1'b0, "after_illegal");
    endtask

    task automatic test_wrap();
        while (exp_count[2:0] != 3'd7) run_instr(6'h02, 6'h00, 1'b0, "wrap_fill");
        run_instr(6'h02, 6'h00, 1'b0, "wrap_step");
        tests++;
        if (s_instr_count !== 3'd0 || instr_count !== exp_count) begin
            fails++; $display("FAIL counter_wrap: small %0d big %h, expected 0 and %h", s_instr_count, instr_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h3f, 6'h00};
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 2) == 0) ? 6'h0d : 6'($urandom);
            run_instr(op, fn, 1'($urandom), "b2b");
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h2b; funct = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (state !== 4'd6 || mem_write !== 1'b1) begin
            fails++; $display("FAIL mid_sw_write: state %0d mem_write %b, expected 6 1", state, mem_write);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            fails++; $display("FAIL mid_reset: state %0d mem_write %b reg_write %b, expected 0 0 0", state, mem_write, reg_write);
        end
        tests++;
        if (instr_count !== 16'd0 || s_instr_count !== 3'd0) begin
            fails++; $display("FAIL mid_reset_count: got %h/%h expected 0", instr_count, s_instr_count);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        exp_count = '0; last_ill = 1'b0;
        run_instr(6'h00, 6'h00, 1'b0, "post_reset_add");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_jump();
        test_illegal();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
